// File: rtl/regfile_stream_loader.sv
// -----------------------------------------------------------------------------
// regfile_stream_loader
//
// Byte-serial loader for a 32 x 32-bit register file. Bytes arrive over a
// valid/ready handshake and are packed MSB-first into 32-bit words. Each
// complete word is written to the next register, starting at a programmed base
// address and wrapping from 31 back to 0. A read port that is always active
// returns register contents two cycles after the address is presented.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-high; clears FSM, counters and memory
//   start          begin a burst (looked at only while idle)
//   start_address  first register written by the burst
//   word_count     words in the burst (0..32; larger values are clamped to 32)
//   in_valid       in_byte carries a valid byte
//   in_byte        stream byte; the first byte of a word becomes bits [31:24]
//   in_ready       loader accepts a byte this cycle
//   busy           burst in progress (any state other than idle)
//   done           one-cycle pulse when the burst completes
//   words_written  words committed in the current or last burst
//   rd_address     read address
//   rd_data        read data, two-cycle latency
// -----------------------------------------------------------------------------
module regfile_stream_loader (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  start_address,
  input  logic [5:0]  word_count,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  output logic        busy,
  output logic        done,
  output logic [5:0]  words_written,
  input  logic [4:0]  rd_address,
  output logic [31:0] rd_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  addr_q, addr_d;
  logic [5:0]  remaining_q, remaining_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] word_q, word_d;
  logic [5:0]  words_written_q, words_written_d;
  logic [31:0] rd_hold_q, rd_hold_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        wr_en;

  logic [31:0] mem_q [32];

  // Outputs are decoded straight from the registered state, so they are glitch
  // free and settle right after the clock edge.
  assign in_ready      = (state_q == S_LOAD);
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign words_written = words_written_q;
  assign rd_data       = rd_data_q;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d         = state_q;
    addr_d          = addr_q;
    remaining_d     = remaining_q;
    byte_cnt_d      = byte_cnt_q;
    word_d          = word_q;
    words_written_d = words_written_q;
    wr_en           = 1'b0;

    // The read pipeline samples the array before this cycle's write lands, so
    // a read of the address being written returns the old contents.
    rd_hold_d = mem_q[rd_address];
    rd_data_d = rd_hold_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          words_written_d = '0;
          if (word_count == 6'd0) begin
            state_d = S_DONE;
          end else begin
            addr_d      = start_address;
            remaining_d = (word_count > 6'd32) ? 6'd32 : word_count;
            byte_cnt_d  = '0;
            state_d     = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        if (in_valid) begin
          word_d     = {word_q[23:0], in_byte};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        wr_en           = 1'b1;
        addr_d          = addr_q + 5'd1;  // 5-bit add wraps 31 -> 0
        remaining_d     = remaining_q - 6'd1;
        words_written_d = words_written_q + 6'd1;
        byte_cnt_d      = '0;
        state_d         = (remaining_q == 6'd1) ? S_DONE : S_LOAD;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // sees the pre-edge value of every other flop regardless of statement order.
    if (reset) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      remaining_q     <= '0;
      byte_cnt_q      <= '0;
      word_q          <= '0;
      words_written_q <= '0;
      rd_hold_q       <= '0;
      rd_data_q       <= '0;
      // NOTE: the register file must read as zero after reset, so it is built
      // from resettable flops rather than a RAM macro without a clear.
      for (int i = 0; i < 32; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remaining_q     <= remaining_d;
      byte_cnt_q      <= byte_cnt_d;
      word_q          <= word_d;
      words_written_q <= words_written_d;
      rd_hold_q       <= rd_hold_d;
      rd_data_q       <= rd_data_d;
      if (wr_en) begin
        mem_q[addr_q] <= word_q;
      end
    end
  end

endmodule

// File: tb/tb_regfile_stream_loader.sv
// -----------------------------------------------------------------------------
// tb_regfile_stream_loader
//
// Self-checking bench for regfile_stream_loader. A plain array models the
// register file; each burst's effect is applied to it as "word i goes to
// (base + i) mod 32". Register contents are read back through the DUT read
// port and compared with the model after every burst.
// -----------------------------------------------------------------------------
module tb_regfile_stream_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  start_address;
  logic [5:0]  word_count;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        busy;
  logic        done;
  logic [5:0]  words_written;
  logic [4:0]  rd_address;
  logic [31:0] rd_data;

  always #5 clk = ~clk;

  regfile_stream_loader dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .start_address (start_address),
    .word_count    (word_count),
    .in_valid      (in_valid),
    .in_byte       (in_byte),
    .in_ready      (in_ready),
    .busy          (busy),
    .done          (done),
    .words_written (words_written),
    .rd_address    (rd_address),
    .rd_data       (rd_data)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem_model   [32];
  logic [31:0] burst_words [32];

  typedef struct {
    logic [4:0] base;
    logic [5:0] count;
    int         gap_pct;
    bit         poke;      // hold start high through the burst
    logic [5:0] exp_ww;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) mem_model[i] = '0;
  endtask

  task automatic read_check(input string tag);
    for (int a = 0; a < 32; a++) begin
      rd_address = a[4:0];
      @(negedge clk);
      @(negedge clk);
      check($sformatf("%s rd[%0d]", tag, a), rd_data, mem_model[a]);
    end
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n && i < 32; i++) burst_words[i] = $urandom;
  endtask

  // Runs one burst using burst_words as the payload. lat returns the cycle
  // distance from the first accepted byte to the done cycle (or from the
  // start edge when nothing is accepted).
  task automatic run_burst(input logic [4:0] base, input logic [5:0] count,
                           input int gap_pct, input bit poke,
                           input logic [5:0] exp_ww, output int lat);
    int  n, k, cyc, first_acc;
    bit  expect_low, finished;
    logic [31:0] w;
    n          = (count > 6'd32) ? 32 : int'(count);
    k          = 0;
    cyc        = 0;
    first_acc  = -1;
    expect_low = 1'b0;
    finished   = 1'b0;
    lat        = -1;

    start         = 1'b1;
    start_address = base;
    word_count    = count;
    @(negedge clk);
    if (poke) begin
      start_address = base + 5'd7;
      word_count    = 6'd1;
    end else begin
      start = 1'b0;
    end

    while (!finished && cyc < 3000) begin
      if (expect_low) check("in_ready low in WRITE", {31'd0, in_ready}, 32'd0);
      expect_low = 1'b0;
      if (done) begin
        lat = (first_acc >= 0) ? cyc - first_acc : cyc;
        check("words_written at done", {26'd0, words_written}, {26'd0, exp_ww});
        check("busy during done", {31'd0, busy}, 32'd1);
        start    = 1'b0;
        in_valid = 1'b0;
        finished = 1'b1;
      end else begin
        in_valid = (k < 4 * n) && ($urandom_range(99) >= gap_pct);
        if (in_valid) begin
          w       = burst_words[k / 4];
          in_byte = w[8 * (3 - k % 4) +: 8];
        end else begin
          in_byte = 8'($urandom);
        end
        if (in_valid && in_ready) begin
          if (first_acc < 0) first_acc = cyc;
          if (k % 4 == 3) expect_low = 1'b1;
          k++;
        end
      end
      @(negedge clk);
      cyc++;
    end

    check("burst completes", {31'd0, finished}, 32'd1);
    check("bytes consumed", k, 4 * n);
    check("done single pulse", {31'd0, done}, 32'd0);
    check("busy cleared", {31'd0, busy}, 32'd0);
    check("in_ready idle", {31'd0, in_ready}, 32'd0);

    for (int i = 0; i < n; i++) mem_model[(int'(base) + i) % 32] = burst_words[i];
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    vec_t v;
    bit   saw_done;
    logic [5:0] cnt;

    reset         = 1'b1;
    start         = 1'b0;
    start_address = '0;
    word_count    = '0;
    in_valid      = 1'b0;
    in_byte       = '0;
    rd_address    = '0;

    // Reset state
    do_reset();
    check("reset in_ready", {31'd0, in_ready}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset words_written", {26'd0, words_written}, 32'd0);
    check("reset rd_data", rd_data, 32'd0);
    read_check("after reset");

    // Three float operands at 22..24, gapless stream, latency to done
    burst_words[0] = 32'h41360000;
    burst_words[1] = 32'h40B2041B;
    burst_words[2] = 32'h41878107;
    run_burst(5'd22, 6'd3, 0, 1'b0, 6'd3, lat);
    check("3-word accept-to-done cycles", lat, 15);
    read_check("float burst");

    // Address wrap 30,31,0,1
    for (int i = 0; i < 4; i++) burst_words[i] = i + 1;
    run_burst(5'd30, 6'd4, 0, 1'b0, 6'd4, lat);
    read_check("wrap burst");

    // Gappy stream, then the same words gapless: model expects identical state
    fill_random(2);
    run_burst(5'd10, 6'd2, 50, 1'b0, 6'd2, lat);
    read_check("gappy burst");
    run_burst(5'd10, 6'd2, 0, 1'b0, 6'd2, lat);
    read_check("gapless repeat");

    // Zero-length burst: done in the first cycle after start, memory unchanged
    run_burst(5'd3, 6'd0, 0, 1'b0, 6'd0, lat);
    check("word_count=0 done latency", lat, 0);
    read_check("zero burst");

    // start held high throughout the burst must be ignored
    fill_random(3);
    run_burst(5'd12, 6'd3, 30, 1'b1, 6'd3, lat);
    read_check("start while busy");

    // Reset after two bytes: no done, memory cleared, then a clean reload
    @(negedge clk);
    start         = 1'b1;
    start_address = 5'd5;
    word_count    = 6'd2;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_byte  = 8'hAA;
    @(negedge clk);
    in_byte  = 8'h55;
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) mem_model[i] = '0;
    saw_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (done) saw_done = 1'b1;
      check("in_ready after mid-burst reset", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    check("no done after mid-burst reset", {31'd0, saw_done}, 32'd0);
    check("busy after mid-burst reset", {31'd0, busy}, 32'd0);
    read_check("mid-burst reset");
    fill_random(2);
    run_burst(5'd5, 6'd2, 0, 1'b0, 6'd2, lat);
    read_check("reload after reset");

    // Table-driven bursts
    tbl[0] = '{5'd0,  6'd32, 0,  1'b0, 6'd32};
    tbl[1] = '{5'd7,  6'd40, 20, 1'b0, 6'd32};
    tbl[2] = '{5'd25, 6'd5,  50, 1'b1, 6'd5};
    tbl[3] = '{5'd31, 6'd1,  0,  1'b0, 6'd1};
    tbl[4] = '{5'd0,  6'd0,  0,  1'b1, 6'd0};
    tbl[5] = '{5'd16, 6'd9,  70, 1'b0, 6'd9};
    for (int t = 0; t < 6; t++) begin
      v = tbl[t];
      fill_random(32);
      run_burst(v.base, v.count, v.gap_pct, v.poke, v.exp_ww, lat);
      read_check($sformatf("table %0d", t));
    end

    // Random bursts
    for (int r = 0; r < 4; r++) begin
      cnt = 6'($urandom_range(33));
      fill_random(32);
      run_burst(5'($urandom), cnt, int'($urandom_range(60)), 1'($urandom),
                (cnt > 6'd32) ? 6'd32 : cnt, lat);
      read_check($sformatf("random %0d", r));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
